// File: rtl/uart_receiver.sv
// UART 8N1 receive path: 16x oversampling, mid-bit sampling, start/stop validation.
// Presents each good byte with a one-cycle strobe and a held valid flag with acknowledge.
module uart_receiver #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter bit          INVERT_DATA = 1'b1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_VALID,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [1:0]      flush_q;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            status_q, status_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            ferr_q, ferr_d;
  logic            active;
  logic            tick;

  // The preset synchroniser value is not a real line sample; flush_q marks when it has been
  // replaced so ARM cannot be fooled by a line held low across reset release.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      flush_q <= 2'b00;
    end else begin
      sync1_q <= UART_RX;
      rxs_q   <= sync1_q;
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  assign active = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign tick   = active && (div_q == DivW'(DIV - 1));

  always_comb begin
    div_d = div_q + DivW'(1);
    if (!active || tick) begin
      div_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    status_d   = 1'b0;
    ferr_d     = 1'b0;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    if (rx_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      StArm: begin
        if (flush_q[1] && rxs_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (!rxs_q) begin
          state_d    = StStart;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            state_d    = rxs_q ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            shift_d    = {rxs_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            if (rxs_q) begin
              data_d   = INVERT_DATA ? ~shift_q : shift_q;
              status_d = 1'b1;
              // Completion wins over a simultaneous acknowledge.
              valid_d  = 1'b1;
              if (valid_q && !rx_ack) begin
                overrun_d = 1'b1;
              end
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StArm;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StArm;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= StArm;
      div_q      <= '0;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_q     <= 8'd0;
      status_q   <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      status_q   <= status_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  // Busy covers frame reception only; ARM is a quiet re-arm wait.
  assign busy      = active;
  assign RX_DATA   = data_q;
  assign RX_STATUS = status_q;
  assign RX_VALID  = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: two instances share one line, one with data inversion
// enabled and one without, so both output polarities are exercised by the same frames.
module tb_uart_receiver;

  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 10_000;
  localparam int          BitCyc  = 160;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rx_ack;
  logic [7:0] data_inv, data_raw;
  logic       status_inv, status_raw, valid_inv, valid_raw;
  logic       ovr_inv, ovr_raw, ferr_inv, ferr_raw, busy_inv, busy_raw;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int status_cnt = 0;
  int ferr_cnt = 0;
  int last_status_cyc = 0;
  int start_cyc = 0;
  int s0, f0, lat;

  uart_receiver #(.CLK_FREQ(ClkFreq), .BAUD(Baud), .INVERT_DATA(1'b1)) u_inv (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (uart_rx),
    .rx_ack    (rx_ack),
    .RX_DATA   (data_inv),
    .RX_STATUS (status_inv),
    .RX_VALID  (valid_inv),
    .overrun   (ovr_inv),
    .frame_err (ferr_inv),
    .busy      (busy_inv)
  );

  uart_receiver #(.CLK_FREQ(ClkFreq), .BAUD(Baud), .INVERT_DATA(1'b0)) u_raw (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (uart_rx),
    .rx_ack    (rx_ack),
    .RX_DATA   (data_raw),
    .RX_STATUS (status_raw),
    .RX_VALID  (valid_raw),
    .overrun   (ovr_raw),
    .frame_err (ferr_raw),
    .busy      (busy_raw)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (status_inv) begin
      status_cnt      <= status_cnt + 1;
      last_status_cyc <= cyc;
    end
    if (ferr_inv) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] bits, input logic stop);
    uart_rx   = 1'b0;
    start_cyc = cyc;
    hold(BitCyc);
    for (int i = 0; i < 8; i++) begin
      uart_rx = bits[i];
      hold(BitCyc);
    end
    uart_rx = stop;
    hold(BitCyc);
    uart_rx = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    hold(1);
    rx_ack = 1'b0;
    hold(2);
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    hold(3);
    check("reset_data", data_inv, 8'h00);
    check("reset_status", status_inv, 1'b0);
    check("reset_valid", valid_inv, 1'b0);
    check("reset_overrun", ovr_inv, 1'b0);
    check("reset_ferr", ferr_inv, 1'b0);
    check("reset_busy", busy_inv, 1'b0);
    reset = 1'b0;
    hold(20);

    // 0x55 on the line as-is: raw instance sees 0x55, inverting instance 0xAA.
    s0 = status_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    hold(20);
    check("raw_data_55", data_raw, 8'h55);
    check("inv_data_55", data_inv, 8'hAA);
    check("status_once_55", status_cnt - s0, 1);
    lat = last_status_cyc - start_cyc;
    check("latency_window", (lat >= 1521 && lat <= 1525), 1'b1);
    check("valid_55", valid_inv, 1'b1);
    check("ferr_none_55", ferr_cnt - f0, 0);
    check("busy_idle", busy_inv, 1'b0);

    ack_pulse();
    check("ack_clears_valid", valid_inv, 1'b0);

    // 0xA3 with data bits inverted on the line.
    send_frame(~8'hA3, 1'b1);
    hold(20);
    check("inv_data_a3", data_inv, 8'hA3);
    check("raw_data_a3", data_raw, 8'h5C);
    check("valid_a3", valid_inv, 1'b1);
    check("no_overrun_a3", ovr_inv, 1'b0);
    ack_pulse();
    check("ack_valid_a3", valid_inv, 1'b0);

    // Back-to-back frames without acknowledge.
    s0 = status_cnt;
    send_frame(~8'h12, 1'b1);
    send_frame(~8'h34, 1'b1);
    hold(20);
    check("b2b_data", data_inv, 8'h34);
    check("b2b_status_twice", status_cnt - s0, 2);
    check("b2b_overrun", ovr_inv, 1'b1);
    check("b2b_valid", valid_inv, 1'b1);
    ack_pulse();
    check("b2b_ack_valid", valid_inv, 1'b0);
    check("b2b_ack_overrun", ovr_inv, 1'b0);

    // Stop bit low: framing error, byte discarded.
    s0 = status_cnt;
    f0 = ferr_cnt;
    send_frame(~8'h99, 1'b0);
    hold(20);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_status", status_cnt - s0, 0);
    check("ferr_data_kept", data_inv, 8'h34);
    check("ferr_valid_kept", valid_inv, 1'b0);
    send_frame(~8'h7E, 1'b1);
    hold(20);
    check("after_ferr_data", data_inv, 8'h7E);
    check("after_ferr_valid", valid_inv, 1'b1);

    // Short low glitch is rejected at the start-bit midpoint.
    s0 = status_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    hold(40);
    uart_rx = 1'b1;
    hold(300);
    check("glitch_no_status", status_cnt - s0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_idle", busy_inv, 1'b0);

    // Reset mid-DATA with the line low; valid is still set from 0x7E.
    uart_rx = 1'b0;
    hold(400);
    check("mid_frame_busy", busy_inv, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_data", data_inv, 8'h00);
    check("async_reset_valid", valid_inv, 1'b0);
    check("async_reset_busy", busy_inv, 1'b0);
    hold(3);
    reset = 1'b0;
    s0 = status_cnt;
    f0 = ferr_cnt;
    hold(500);
    check("low_line_no_status", status_cnt - s0, 0);
    check("low_line_no_ferr", ferr_cnt - f0, 0);
    check("low_line_not_busy", busy_inv, 1'b0);
    uart_rx = 1'b1;
    hold(50);
    send_frame(~8'hC9, 1'b1);
    hold(20);
    check("post_reset_data", data_inv, 8'hC9);
    check("post_reset_status", status_cnt - s0, 1);
    check("post_reset_valid", valid_inv, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
